// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter and its bus clients:
// FSM state encoding, hold-counter width and the unit source codes driven on CDB_source.
package cdb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } cdb_state_e;

    // Wide enough for HOLD_CYCLES-1 with HOLD_CYCLES up to 15
    localparam int CNT_W = 4;

    localparam logic [5:0] NO_UNIT = 6'b000000;
    localparam logic [5:0] ADDER_1 = 6'b000001;
    localparam logic [5:0] ADDER_2 = 6'b000010;
    localparam logic [5:0] ADDER_3 = 6'b000011;
    localparam logic [5:0] MULT_1  = 6'b000100;
    localparam logic [5:0] MULT_2  = 6'b000101;
    localparam logic [5:0] LOAD_1  = 6'b000110;
    localparam logic [5:0] LOAD_2  = 6'b000111;
    localparam logic [5:0] LOAD_3  = 6'b001000;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Purpose: round-robin picker, first set request at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    localparam int W1 = ID_W + 1;

    logic [W1-1:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i stays below 2N, so one conditional subtract is a full modulo
            sum = {1'b0, ptr} + W1'(i);
            if (sum >= W1'(N)) begin
                sum = sum - W1'(N);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter granting the shared result bus to one functional unit at a time.
// Latency: rts to xmit in one edge; grant held HOLD_CYCLES, then one release bubble and one idle cycle.
// Backpressure: units wait on rts; requests are only sampled in IDLE, never revoked mid-grant.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_UNITS     = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int ID_W        = $clog2(N_UNITS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_UNITS-1:0] rts,
    input  logic               CDB_write,
    output logic [N_UNITS-1:0] xmit,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               protocol_error
);

    cdb_state_e         state_q, state_d;
    logic [N_UNITS-1:0] xmit_q, xmit_d;
    logic               grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               seen_write_q, seen_write_d;
    logic               perr_q, perr_d;

    logic [ID_W-1:0]    pick_winner;
    logic               pick_found;

    rr_pick #(
        .N    (N_UNITS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (rts),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .found  (pick_found)
    );

    always_comb begin
        state_d       = state_q;
        xmit_d        = xmit_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        seen_write_d  = seen_write_q;
        perr_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    xmit_d        = N_UNITS'(1) << pick_winner;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_winner;
                    cnt_d         = CNT_W'(HOLD_CYCLES - 1);
                    seen_write_d  = 1'b0;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                seen_write_d = seen_write_q | CDB_write;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    xmit_d        = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    ptr_d         = (grant_id_q == ID_W'(N_UNITS - 1)) ? '0 : grant_id_q + 1'b1;
                    // The write on the final grant edge still counts as a valid transfer
                    perr_d        = ~(seen_write_q | CDB_write);
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            xmit_q        <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            ptr_q         <= '0;
            seen_write_q  <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            xmit_q        <= xmit_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            seen_write_q  <= seen_write_d;
            perr_q        <= perr_d;
        end
    end

    assign xmit           = xmit_q;
    assign grant_valid    = grant_valid_q;
    assign grant_id       = grant_id_q;
    assign busy           = (state_q != ST_IDLE);
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant starts on the HOLD_CYCLES=1 instance are matched against a
// queue of expected winners and start-to-start gaps; a HOLD_CYCLES=2 instance covers protocol_error.
module tb_cdb_arbiter;

    typedef struct {
        int id;
        int gap;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] rts;
    logic       cdb_write;
    logic [3:0] xmit;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       busy;
    logic       protocol_error;

    logic [3:0] rts2;
    logic       cdb_write2;
    logic [3:0] xmit2;
    logic       grant_valid2;
    logic [1:0] grant_id2;
    logic       busy2;
    logic       protocol_error2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_start = -1;
    logic gv_prev = 1'b0;
    exp_t exp_q[$];

    cdb_arbiter #(.N_UNITS(4), .HOLD_CYCLES(1), .ID_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .rts            (rts),
        .CDB_write      (cdb_write),
        .xmit           (xmit),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    cdb_arbiter #(.N_UNITS(4), .HOLD_CYCLES(2), .ID_W(2)) dut_h2 (
        .clock          (clock),
        .reset          (reset),
        .rts            (rts2),
        .CDB_write      (cdb_write2),
        .xmit           (xmit2),
        .grant_valid    (grant_valid2),
        .grant_id       (grant_id2),
        .busy           (busy2),
        .protocol_error (protocol_error2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int id, input int gap);
        exp_t e;
        e.id  = id;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 40) begin
            tick(1);
            k++;
        end
        n_tests++;
        assert (k < 40) else begin
            n_fail++;
            $error("FAIL idle_timeout: observed busy=%0b pending=%0d required drained", busy, exp_q.size());
        end
    endtask

    // Scoreboard: every rising grant_valid on the main instance consumes one expected grant
    always @(negedge clock) begin
        exp_t e;
        if (!reset && grant_valid && !gv_prev) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_grant: observed id %0d required no grant", grant_id);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_grant_id", 32'(grant_id), 32'(e.id));
                check("sb_xmit", 32'(xmit), 32'(1) << e.id);
                if (e.gap >= 0) begin
                    check("sb_gap", 32'(cyc - last_start), 32'(e.gap));
                end
            end
            last_start = cyc;
        end
        gv_prev = grant_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        rts        = 4'b1111;
        cdb_write  = 1'b0;
        rts2       = 4'b0000;
        cdb_write2 = 1'b0;

        // Reset held with all units requesting
        tick(3);
        check("rst_xmit", 32'(xmit), 32'h0);
        check("rst_grant_valid", 32'(grant_valid), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_perr", 32'(protocol_error), 32'h0);

        // Fairness: all requesting from ptr=0 gives 0,1,2,3 every 3 cycles
        push(0, -1);
        push(1, 3);
        push(2, 3);
        push(3, 3);
        reset = 1'b0;
        tick(1);
        check("first_xmit", 32'(xmit), 32'h1);
        check("first_grant_id", 32'(grant_id), 32'h0);
        check("first_busy", 32'(busy), 32'h1);
        tick(9);
        rts = 4'b0000;
        wait_idle();

        // Single request with a write during the grant
        rts = 4'b0100;
        push(2, -1);
        tick(1);
        check("single_xmit", 32'(xmit), 32'h4);
        rts       = 4'b0000;
        cdb_write = 1'b1;
        tick(1);
        cdb_write = 1'b0;
        check("single_rel_xmit", 32'(xmit), 32'h0);
        check("single_rel_perr", 32'(protocol_error), 32'h0);
        check("single_rel_gv", 32'(grant_valid), 32'h0);
        check("single_rel_gid", 32'(grant_id), 32'h0);
        check("single_rel_busy", 32'(busy), 32'h1);
        tick(1);
        check("single_idle_xmit", 32'(xmit), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Contention across the wrap (ptr=3), then 0 must wait behind 1
        rts = 4'b1001;
        push(3, -1);
        push(0, 3);
        tick(1);
        check("wrap_xmit", 32'(xmit), 32'h8);
        tick(3);
        rts = 4'b0011;
        push(1, 3);
        push(0, 3);
        tick(6);
        rts = 4'b0000;
        wait_idle();

        // Protocol error on the HOLD_CYCLES=2 instance: unit 1 never writes
        rts2 = 4'b0010;
        tick(1);
        check("perr_grant_xmit", 32'(xmit2), 32'h2);
        check("perr_grant_id", 32'(grant_id2), 32'h1);
        rts2 = 4'b0000;
        tick(1);
        check("perr_hold_xmit", 32'(xmit2), 32'h2);
        check("perr_hold_perr", 32'(protocol_error2), 32'h0);
        tick(1);
        check("perr_rel_xmit", 32'(xmit2), 32'h0);
        check("perr_rel_perr", 32'(protocol_error2), 32'h1);
        check("perr_rel_busy", 32'(busy2), 32'h1);
        tick(1);
        check("perr_idle_perr", 32'(protocol_error2), 32'h0);
        check("perr_idle_busy", 32'(busy2), 32'h0);

        // Reset one ns after a grant edge (ptr=1 beforehand)
        rts = 4'b0100;
        tick(1);
        check("midrst_pre_xmit", 32'(xmit), 32'h4);
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("midrst_xmit", 32'(xmit), 32'h0);
        check("midrst_gv", 32'(grant_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rts = 4'b0000;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("postrst_busy", 32'(busy), 32'h0);
        rts = 4'b1111;
        push(0, -1);
        tick(1);
        check("postrst_ptr0_xmit", 32'(xmit), 32'h1);
        rts = 4'b0000;
        wait_idle();

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
